// File: rtl/id_issue_queue.sv
// id_issue_queue: IF/ID instruction FIFO with head pre-decode and a load-use scoreboard
//   clk, rst (async active-low)
//   in_valid/in_ready/in_pc/in_inst       : fetch side handshake
//   out_valid/out_ready/out_pc/out_inst   : issue side handshake
//   out_op1_read/out_op2_read/out_is_load : pre-decode of the presented instruction
//   ld_done_ena/ld_done_addr              : load writeback, releases one pending load on rd
//   flush                                 : empties the queue, scoreboard untouched
//   hazard_stall                          : head present but blocked by a pending load
//   count                                 : occupied entries
// Optional: YSYX22040228_IDQ_BYPASS_EN adds a 0-cycle in->out path when the queue is empty.
module id_issue_queue #(
   parameter int DEPTH  = 4,
   parameter int PC_W   = 64,
   parameter int INST_W = 32,
   parameter int CNT_W  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [PC_W-1:0]          in_pc,
   input  logic [INST_W-1:0]        in_inst,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PC_W-1:0]          out_pc,
   output logic [INST_W-1:0]        out_inst,
   output logic                     out_op1_read,
   output logic                     out_op2_read,
   output logic                     out_is_load,
   input  logic                     ld_done_ena,
   input  logic [4:0]               ld_done_addr,
   input  logic                     flush,
   output logic                     hazard_stall,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [PC_W-1:0]   pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];
   logic [AW-1:0]     head, tail;
   logic [CNT_W-1:0]  sb [32];
   logic              head_valid, byp, show, haz, rd1, rd2, ld, push, pop, pop_head, inc, dec;
   logic [PC_W-1:0]   sel_pc;
   logic [INST_W-1:0] sel_inst;
   logic [6:0]        op;
   logic [2:0]        f3;
   logic [4:0]        rs1, rs2, rd;

   assign head_valid = count != '0;
   // DEPTH is a power of two, so the top count bit is set exactly when full
   assign in_ready   = rst && !count[AW];
   // decode the head when present, otherwise the incoming word (bypass candidate)
   assign sel_pc     = head_valid ? pc_mem[head] : in_pc;
   assign sel_inst   = head_valid ? inst_mem[head] : in_inst;
   assign op         = sel_inst[6:0];
   assign f3         = sel_inst[14:12];
   assign rd         = sel_inst[11:7];
   assign rs1        = sel_inst[19:15];
   assign rs2        = sel_inst[24:20];
   assign rd1 = (op inside {7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011,
                            7'b1100011, 7'b0000011, 7'b0100011, 7'b1100111})
                || (op == 7'b1110011 && f3 inside {3'b001, 3'b010, 3'b011});
   assign rd2 = op inside {7'b0110011, 7'b0111011, 7'b1100011, 7'b0100011};
   assign ld  = op == 7'b0000011;
   // x0 counter is held at zero, so reads of x0 never hazard
   assign haz = (rd1 && sb[rs1] != '0) || (rd2 && sb[rs2] != '0) || (ld && sb[rd] == '1);
`ifdef YSYX22040228_IDQ_BYPASS_EN
   assign byp = !head_valid && in_valid && rst && !flush && !haz;
`else
   assign byp = 1'b0;
`endif
   assign show         = head_valid || byp;
   assign out_valid    = show && !haz;
   assign hazard_stall = head_valid && haz;
   assign out_pc       = show ? sel_pc : '0;
   assign out_inst     = show ? sel_inst : '0;
   assign out_op1_read = show && rd1;
   assign out_op2_read = show && rd2;
   assign out_is_load  = show && ld;
   assign pop      = out_valid && out_ready && !flush;
   assign pop_head = pop && head_valid;
   // a bypassed instruction that is accepted is never written
   assign push     = in_valid && in_ready && !flush && !(byp && out_ready);
   assign inc      = pop && ld && rd != 5'd0;
   assign dec      = ld_done_ena && sb[ld_done_addr] != '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < 32; i++) sb[i] <= '0;
      end else begin
         head  <= flush ? '0 : head + AW'(pop_head);
         tail  <= flush ? '0 : tail + AW'(push);
         count <= flush ? '0 : count + (AW+1)'(push) - (AW+1)'(pop_head);
         // increment and decrement on the same register cancel
         for (int i = 1; i < 32; i++)
            if ((inc && rd == 5'(i)) != (dec && ld_done_addr == 5'(i)))
               sb[i] <= (inc && rd == 5'(i)) ? sb[i] + 1'b1 : sb[i] - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[tail]   <= in_pc;
         inst_mem[tail] <= in_inst;
      end
   end
endmodule

// File: tb/tb_id_issue_queue.sv
// tb_id_issue_queue: directed scoreboard bench for id_issue_queue
module tb_id_issue_queue;
   localparam logic [31:0] NOP   = 32'h00000013;
   localparam logic [31:0] ADDI1 = 32'h00100093;
   localparam logic [31:0] LW5   = 32'h00002283;
   localparam logic [31:0] ADD6  = 32'h00728333;
   localparam logic [31:0] LW8   = 32'h00002403;
   localparam logic [31:0] ADD9  = 32'h000404B3;
   logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
   logic [63:0] in_pc, out_pc;
   logic [31:0] in_inst, out_inst;
   logic        out_op1_read, out_op2_read, out_is_load, ld_done_ena, flush, hazard_stall;
   logic [4:0]  ld_done_addr;
   logic [2:0]  count;
   int          checks = 0, failures = 0;
   logic [95:0] exp_q [$];
   logic [95:0] e;

   id_issue_queue dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_inst(out_inst), .out_op1_read(out_op1_read), .out_op2_read(out_op2_read),
      .out_is_load(out_is_load), .ld_done_ena(ld_done_ena), .ld_done_addr(ld_done_addr),
      .flush(flush), .hazard_stall(hazard_stall), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
      checks++;
      if (a !== x) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", n, a, x);
      end
   endtask

   // one cycle: drive after the rising edge, return at the falling edge for checks
   task automatic cyc(input logic iv, input logic [63:0] pc, input logic [31:0] inst,
                      input logic ordy, input logic ld, input logic [4:0] la, input logic fl);
      @(posedge clk);
      #1;
      in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
      ld_done_ena = ld; ld_done_addr = la; flush = fl;
      @(negedge clk);
   endtask

   // scoreboard: accepted inputs queue up, delivered outputs must match in order
   always @(negedge clk) begin
      if (!rst || flush) exp_q.delete();
      else begin
         if (in_valid && in_ready) exp_q.push_back({in_pc, in_inst});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL deliver: got pc %0h expected nothing", out_pc);
            end else begin
               e = exp_q.pop_front();
               chk("out_pc", out_pc, e[95:32]);
               chk("out_inst", {32'd0, out_inst}, {32'd0, e[31:0]});
            end
         end
      end
   end

   initial begin
      rst = 1'b0; in_valid = 0; in_pc = 0; in_inst = 0; out_ready = 0;
      ld_done_ena = 0; ld_done_addr = 0; flush = 0;
      @(negedge clk);
      chk("rst_count", count, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_stall", hazard_stall, 0);
      chk("rst_out_pc", out_pc, 0);
      @(posedge clk); #1; rst = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", in_ready, 1);
      // reset mid-operation
      for (int i = 0; i < 3; i++) cyc(1, 64'h100 + 4 * i, NOP, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("pre_rst_count", count, 3);
      @(posedge clk); #1; rst = 1'b0; #1;
      chk("mid_rst_count", count, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      #4; rst = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      // fill, then drain with concurrent pushes across pointer wrap
      for (int i = 0; i < 4; i++) cyc(1, 64'h200 + 4 * i, NOP, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("full_count", count, 4);
      chk("full_in_ready", in_ready, 0);
      chk("full_out_valid", out_valid, 1);
      chk("full_out_pc", out_pc, 64'h200);
      cyc(0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 64'h210 + 4 * i, NOP, 1, 0, 0, 0);
         chk("steady_count", count, 3);
         chk("steady_in_ready", in_ready, 1);
      end
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("drained_count", count, 0);
      chk("empty_out_pc", out_pc, 0);
      chk("empty_op1", out_op1_read, 0);
      // load-use
      cyc(1, 64'h300, LW5, 0, 0, 0, 0);
      cyc(1, 64'h304, ADD6, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("lw_valid", out_valid, 1);
      chk("lw_is_load", out_is_load, 1);
      chk("lw_op1", out_op1_read, 1);
      chk("lw_op2", out_op2_read, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("use_stall", hazard_stall, 1);
      chk("use_valid", out_valid, 0);
      chk("use_op2", out_op2_read, 1);
      chk("use_pc", out_pc, 64'h304);
      cyc(0, 0, 0, 1, 1, 5, 0);
      chk("done_no_fwd", out_valid, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("done_release", out_valid, 1);
      chk("done_stall", hazard_stall, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("lu_count", count, 0);
      // counter saturation on x8
      for (int i = 0; i < 4; i++) cyc(1, 64'h400 + 4 * i, LW8, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 1, 0, 0, 0);
         chk("sat_issue", out_valid, 1);
      end
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("sat_stall", hazard_stall, 1);
      chk("sat_valid", out_valid, 0);
      cyc(0, 0, 0, 1, 1, 8, 0);
      chk("sat_stall_done", hazard_stall, 1);
      cyc(0, 0, 0, 1, 1, 8, 0);
      chk("sat_issue_done", out_valid, 1);
      cyc(1, 64'h410, ADD9, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("sat_cnt2_stall", hazard_stall, 1);
      chk("sat_cnt2_count", count, 1);
      cyc(0, 0, 0, 1, 1, 8, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("sat_cnt1_stall", hazard_stall, 1);
      cyc(0, 0, 0, 1, 1, 8, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("sat_cnt0_valid", out_valid, 1);
      cyc(0, 0, 0, 0, 1, 8, 0);
      chk("sat_cnt0_count", count, 0);
      cyc(1, 64'h414, ADD9, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("no_underflow_valid", out_valid, 1);
      chk("no_underflow_stall", hazard_stall, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      // flush with push and pop asserted
      cyc(1, 64'h500, LW5, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(1, 64'h504, NOP, 0, 0, 0, 0);
      cyc(1, 64'h508, NOP, 0, 0, 0, 0);
      cyc(1, 64'h50C, NOP, 1, 0, 0, 1);
      chk("pre_flush_count", count, 2);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("flush_count", count, 0);
      chk("flush_valid", out_valid, 0);
      cyc(1, 64'h510, ADD6, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("flush_sb_kept", hazard_stall, 1);
      cyc(0, 0, 0, 1, 1, 5, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("flush_release", out_valid, 1);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("flush_end_count", count, 0);
      // latency from an empty queue
`ifdef YSYX22040228_IDQ_BYPASS_EN
      cyc(1, 64'h600, ADDI1, 1, 0, 0, 0);
      chk("byp_valid", out_valid, 1);
      chk("byp_pc", out_pc, 64'h600);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("byp_count", count, 0);
      chk("byp_after_valid", out_valid, 0);
`else
      cyc(1, 64'h600, ADDI1, 1, 0, 0, 0);
      chk("nobyp_valid0", out_valid, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("nobyp_valid1", out_valid, 1);
      chk("nobyp_count", count, 1);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("nobyp_end_count", count, 0);
`endif
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("all_delivered", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
